prio_grant_queue: RTL and testbench
===================================

Name: prio_grant_queue

Overview:
- Sits directly downstream of the 4-bit priority encoder. Consumes its registered index output (Y) and valid flag.
- Buffers each valid encoded index in a small FIFO. Presents entries to a grant consumer through a valid/ready handshake.
- Reports occupancy, overflow, and a saturating count of dropped indices.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2, minimum 2.
- IDX_W, 2, width of the encoded index (matches encoder Y).
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset; rst=0 resets all state immediately.
- in_valid  input  1  encoder valid; an index is offered this cycle.
- in_idx  input  IDX_W  encoder index Y.
- out_ready  input  1  consumer accepts the head entry this cycle.
- clr_ovf  input  1  synchronous clear of overflow and drop_cnt.
- out_valid  output  1  FIFO non-empty; head entry is available.
- out_idx  output  IDX_W  head entry (first-word fall-through).
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky; set when an offered index was dropped.
- drop_cnt  output  DROP_W  saturating number of dropped indices.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers=0, count=0, empty=1, full=0, out_valid=0.
  - out_idx=0, overflow=0, drop_cnt=0.
  - FIFO storage contents don't care.
- pop = out_valid & out_ready.
- push = in_valid & (!full | pop). A push is accepted when full if a pop occurs in the same cycle.
- Push writes in_idx at wr_ptr. wr_ptr increments modulo DEPTH.
- Pop advances rd_ptr modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push & pop, or on neither.
- Simultaneous push & pop when empty is impossible (out_valid=0), so push alone occurs.
- out_valid = !empty, registered/derived from count.
- out_idx = storage[rd_ptr]. It is driven to 0 when empty. It is never X.
- Latency: index pushed at edge N is visible on out_idx/out_valid after edge N, when it is at the head. Minimum in-to-out latency is 1 cycle.
- Ordering is strict FIFO. No reordering or merging of duplicate indices.
- out_ready while empty has no effect.
- Drop: in_valid & full & !pop.
  - Index discarded; storage and pointers unchanged.
  - overflow<=1.
  - drop_cnt<=drop_cnt+1, saturating at 2^DROP_W-1 (no wrap).
- clr_ovf=1: overflow<=0, drop_cnt<=0.
- clr_ovf=1 in the same cycle as a drop: the drop wins, giving overflow<=1 and drop_cnt<=1.
- clr_ovf does not affect FIFO contents or count.
- Reset asserted mid-operation flushes the FIFO immediately. There is no output glitch beyond an asynchronous drop to reset values.
- First push is accepted on the first rising edge after rst deasserts.

Test Plan:
- Reset: rst=0 with in_valid=1 held -> count=0, empty=1, out_valid=0, overflow=0, drop_cnt=0. After rst=1, a push of in_idx=2 gives out_valid=1, out_idx=2 one cycle later.
- Order, out_ready=0: push 3,1,0,2 on consecutive cycles -> full=1, count=4. Then out_ready=1 -> out_idx sequence 3,1,0,2, then empty=1.
- Overflow: fill to full, offer in_idx=1 with out_ready=0 for 3 cycles -> overflow=1, drop_cnt=3, contents unchanged. Then clr_ovf=1 -> overflow=0, drop_cnt=0.
- Full push+pop: full, in_valid=1 with in_idx=3 and out_ready=1 -> count stays 4, no drop, 3 appears last in the pop order.
- Saturation/clear race: DROP_W=2, 5 drops -> drop_cnt=3. Then clr_ovf=1 together with a drop -> drop_cnt=1, overflow=1.
- Reset mid-stream: count=2, assert rst=0 between edges -> outputs go to reset values immediately. Next pushed index is the head after release.

Source files
------------

// File: rtl/prio_grant_queue.sv
// prio_grant_queue
//   Small FIFO placed after the 4-bit priority encoder. Each valid encoded
//   index is buffered and handed to a grant consumer over a valid/ready
//   handshake with first-word fall-through. Offers made while the queue is
//   full (and not draining) are dropped, flagged by a sticky overflow bit
//   and tallied in a saturating drop counter.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   in_valid   encoder valid, an index is offered this cycle
//   in_idx     encoder index
//   out_ready  consumer accepts the head entry this cycle
//   clr_ovf    synchronous clear of overflow and drop_cnt
//   out_valid  head entry available (queue non-empty)
//   out_idx    head entry, 0 when empty
//   count      occupancy 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky, an offered index was dropped
//   drop_cnt   saturating number of dropped indices
module prio_grant_queue #(
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 2,
    parameter int DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [IDX_W-1:0]           in_idx,
    input  logic                       out_ready,
    input  logic                       clr_ovf,
    output logic                       out_valid,
    output logic [IDX_W-1:0]           out_idx,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic pop;
    logic push;
    logic drop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = !empty;
    // Storage is not reset, so the head is masked while empty to keep out_idx defined.
    assign out_idx   = empty ? '0 : mem[rd_ptr];

    assign pop  = out_valid & out_ready;
    // A full queue still accepts an offer when the head leaves in the same cycle.
    assign push = in_valid & (!full | pop);
    assign drop = in_valid & full & !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_idx;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap modulo DEPTH naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A drop in the same cycle as clr_ovf wins: the clear is applied first, then the drop counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= DROP_W'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_prio_grant_queue.sv
// tb_prio_grant_queue
//   Directed bench for prio_grant_queue (DEPTH=4, IDX_W=2, DROP_W=2).
//   Accepted pushes are queued as expected head values; a monitor compares
//   out_idx against the queue whenever a pop is about to happen. Status
//   outputs are compared against hand-computed constants.
module tb_prio_grant_queue;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_idx;
    logic       out_ready;
    logic       clr_ovf;
    logic       out_valid;
    logic [1:0] out_idx;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [1:0] drop_cnt;

    int checks;
    int passes;
    logic [1:0] sbq [$];

    prio_grant_queue #(
        .DEPTH  (4),
        .IDX_W  (2),
        .DROP_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_idx    (in_idx),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_idx(input logic [1:0] v);
        in_valid = 1'b1;
        in_idx   = v;
        sbq.push_back(v);
        step();
    endtask

    // Monitor: a pop happens on the next rising edge when valid & ready at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pop", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    chk("pop_idx", 32'(out_idx), 32'(sbq.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        passes    = 0;
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_idx    = 2'd3;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;

        // Reset with in_valid held
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_idx", 32'(out_idx), 0);
        step();
        step();
        chk("rst_hold_count", 32'(count), 0);
        chk("rst_hold_ovf", 32'(overflow), 0);
        chk("rst_hold_drop", 32'(drop_cnt), 0);
        chk("rst_full", 32'(full), 0);

        // First push after release
        rst = 1'b1;
        push_idx(2'd2);
        in_valid = 1'b0;
        chk("first_valid", 32'(out_valid), 1);
        chk("first_idx", 32'(out_idx), 2);
        chk("first_count", 32'(count), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("first_drain_empty", 32'(empty), 1);
        chk("empty_idx_zero", 32'(out_idx), 0);

        // Order with out_ready low, then drain
        push_idx(2'd3);
        push_idx(2'd1);
        push_idx(2'd0);
        push_idx(2'd2);
        in_valid = 1'b0;
        chk("order_full", 32'(full), 1);
        chk("order_count", 32'(count), 4);
        chk("order_head", 32'(out_idx), 3);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("order_empty", 32'(empty), 1);
        chk("order_count0", 32'(count), 0);
        out_ready = 1'b0;

        // Overflow: three drops while full
        push_idx(2'd0);
        push_idx(2'd1);
        push_idx(2'd2);
        push_idx(2'd3);
        in_idx = 2'd1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drop3", 32'(drop_cnt), 3);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_head", 32'(out_idx), 0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_drop", 32'(drop_cnt), 0);
        chk("clr_count", 32'(count), 4);

        // Full with simultaneous push and pop: no drop, 3 goes to the tail
        out_ready = 1'b1;
        push_idx(2'd3);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("pp_count", 32'(count), 4);
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_drop", 32'(drop_cnt), 0);
        chk("pp_head", 32'(out_idx), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("pp_empty", 32'(empty), 1);
        // out_ready while empty is harmless
        step();
        chk("idle_ready_count", 32'(count), 0);
        chk("idle_ready_valid", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Saturation and clear/drop race
        push_idx(2'd2);
        push_idx(2'd2);
        push_idx(2'd1);
        push_idx(2'd0);
        in_idx = 2'd0;
        for (int i = 0; i < 5; i++) step();
        chk("sat_drop", 32'(drop_cnt), 3);
        chk("sat_ovf", 32'(overflow), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf  = 1'b0;
        in_valid = 1'b0;
        chk("race_drop", 32'(drop_cnt), 1);
        chk("race_ovf", 32'(overflow), 1);
        chk("race_count", 32'(count), 4);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        chk("sat_drain_empty", 32'(empty), 1);

        // Reset mid-stream between edges
        push_idx(2'd1);
        push_idx(2'd3);
        in_valid = 1'b0;
        chk("mid_count", 32'(count), 2);
        #2;
        rst = 1'b0;
        sbq.delete();
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_idx", 32'(out_idx), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        step();
        rst = 1'b1;
        push_idx(2'd2);
        in_valid = 1'b0;
        chk("mid_new_head", 32'(out_idx), 2);
        chk("mid_new_count", 32'(count), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("final_empty", 32'(empty), 1);
        chk("sb_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
